multiexp_pnt_scl_feeder: RTL and testbench

//  Source side of the multiexp point/scalar stream: buffers NUM_IN {point, scalar} pairs

---
 rtl/multiexp_pnt_scl_feeder.sv | 213 +++++++++++++++++++++
 tb/tb_multiexp_pnt_scl_feeder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiexp_pnt_scl_feeder.sv
// Point/scalar source for multiexp_core: buffers NUM_IN {point, scalar} pairs loaded over a
// stream, then replays them KEY_BITS times (normal) or as a single beat (single-add mode).
module multiexp_pnt_scl_feeder #(
    parameter int unsigned FP_BITS  = 8,
    parameter int unsigned FE_BITS  = 8,
    parameter int unsigned KEY_BITS = 256,
    parameter int unsigned CTL_BITS = 8,
    parameter int unsigned NUM_IN   = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_load_val,
    input  logic                        i_load_sop,
    input  logic [FP_BITS+FE_BITS-1:0]  i_load_dat,
    output logic                        o_load_rdy,
    output logic                        o_pnt_scl_val,
    output logic                        o_pnt_scl_sop,
    output logic                        o_pnt_scl_eop,
    output logic [CTL_BITS-1:0]         o_pnt_scl_ctl,
    output logic [FP_BITS+FE_BITS-1:0]  o_pnt_scl_dat,
    input  logic                        i_pnt_scl_rdy,
    input  logic                        i_start,
    input  logic                        i_mode,
    output logic                        o_loaded,
    output logic                        o_busy,
    output logic                        o_done
);
    localparam int unsigned W  = FP_BITS + FE_BITS;
    localparam int unsigned CW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int unsigned PW = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_IN - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(KEY_BITS - 1);

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   mem_q [NUM_IN];
    logic           load_rdy_q, load_rdy_d;
    logic           loaded_q, loaded_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           mode_q, mode_d;
    logic           iss_en_q, iss_en_d;
    logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
    logic [PW-1:0]  pass_cnt_q, pass_cnt_d;
    // s1 = prefetch/skid stage holding the synchronous memory read
    logic           s1_val_q, s1_val_d, s1_sop_q, s1_sop_d, s1_eop_q, s1_eop_d;
    logic           s1_last_q, s1_last_d, s1_mode_q, s1_mode_d;
    logic [W-1:0]   s1_dat_q;
    logic           out_val_q, out_val_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
    logic           out_last_q, out_last_d, out_mode_q, out_mode_d;
    logic [W-1:0]   out_dat_q, out_dat_d;

    logic           ld_hs_c, start_acc_c, iss_c, iss_single_c, iss_last_c;
    logic           out_adv_c, hs_c, finish_c;
    logic [CW-1:0]  wr_addr_c, iss_addr_c;
    logic [PW-1:0]  iss_pass_c;

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        load_rdy_d = load_rdy_q;
        loaded_d   = loaded_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mode_d     = mode_q;
        iss_en_d   = iss_en_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        pass_cnt_d = pass_cnt_q;
        s1_val_d   = s1_val_q;
        s1_sop_d   = s1_sop_q;
        s1_eop_d   = s1_eop_q;
        s1_last_d  = s1_last_q;
        s1_mode_d  = s1_mode_q;
        out_val_d  = out_val_q;
        out_sop_d  = out_sop_q;
        out_eop_d  = out_eop_q;
        out_last_d = out_last_q;
        out_mode_d = out_mode_q;
        out_dat_d  = out_dat_q;

        ld_hs_c     = (state_q == ST_IDLE) && load_rdy_q && i_load_val;
        wr_addr_c   = i_load_sop ? '0 : wr_cnt_q;
        start_acc_c = (state_q == ST_IDLE) && loaded_q && i_start && !ld_hs_c;

        if (ld_hs_c) begin
            if (wr_addr_c == LAST_IDX) begin
                loaded_d = 1'b1;
                wr_cnt_d = '0;
            end else begin
                wr_cnt_d = wr_addr_c + CW'(1);
                if (i_load_sop) loaded_d = 1'b0;
            end
        end

        out_adv_c = !out_val_q || i_pnt_scl_rdy;
        hs_c      = out_val_q && i_pnt_scl_rdy;
        finish_c  = hs_c && out_last_q;

        // The start cycle itself issues entry 0 so the first beat appears two cycles later
        iss_addr_c   = start_acc_c ? '0 : rd_cnt_q;
        iss_pass_c   = start_acc_c ? (i_mode ? '0 : LAST_PASS) : pass_cnt_q;
        iss_single_c = start_acc_c ? i_mode : mode_q;
        iss_last_c   = iss_single_c || ((iss_addr_c == LAST_IDX) && (iss_pass_c == '0));
        iss_c        = start_acc_c ||
                       ((state_q == ST_STREAM) && iss_en_q && (!s1_val_q || out_adv_c));

        if (out_adv_c) begin
            out_val_d = s1_val_q;
            if (s1_val_q) begin
                out_sop_d  = s1_sop_q;
                out_eop_d  = s1_eop_q;
                out_last_d = s1_last_q;
                out_mode_d = s1_mode_q;
                out_dat_d  = s1_dat_q;
            end
        end

        if (iss_c) begin
            s1_val_d   = 1'b1;
            s1_sop_d   = (iss_addr_c == '0);
            s1_eop_d   = (iss_addr_c == LAST_IDX);
            s1_last_d  = iss_last_c;
            s1_mode_d  = iss_single_c;
            iss_en_d   = !iss_last_c;
            rd_cnt_d   = (iss_addr_c == LAST_IDX) ? '0 : iss_addr_c + CW'(1);
            pass_cnt_d = (iss_addr_c == LAST_IDX) ? iss_pass_c - PW'(1) : iss_pass_c;
        end else if (out_adv_c) begin
            s1_val_d = 1'b0;
        end

        if (start_acc_c) begin
            mode_d  = i_mode;
            busy_d  = 1'b1;
            state_d = ST_STREAM;
        end
        if (finish_c) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
        if ((state_q == ST_STREAM) && done_q) state_d = ST_IDLE;

        load_rdy_d = (state_d == ST_IDLE);
    end

    // Control and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            load_rdy_q <= 1'b0;
            loaded_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mode_q     <= 1'b0;
            iss_en_q   <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            pass_cnt_q <= '0;
            s1_val_q   <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mode_q  <= 1'b0;
            out_val_q  <= 1'b0;
            out_sop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_mode_q <= 1'b0;
            out_dat_q  <= '0;
        end else begin
            state_q    <= state_d;
            load_rdy_q <= load_rdy_d;
            loaded_q   <= loaded_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mode_q     <= mode_d;
            iss_en_q   <= iss_en_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            s1_val_q   <= s1_val_d;
            s1_sop_q   <= s1_sop_d;
            s1_eop_q   <= s1_eop_d;
            s1_last_q  <= s1_last_d;
            s1_mode_q  <= s1_mode_d;
            out_val_q  <= out_val_d;
            out_sop_q  <= out_sop_d;
            out_eop_q  <= out_eop_d;
            out_last_q <= out_last_d;
            out_mode_q <= out_mode_d;
            out_dat_q  <= out_dat_d;
        end
    end

    // Buffer storage with registered read port
    always_ff @(posedge i_clk) begin
        if (ld_hs_c) mem_q[wr_addr_c] <= i_load_dat;
        if (iss_c)   s1_dat_q <= mem_q[iss_addr_c];
    end

    assign o_load_rdy    = load_rdy_q;
    assign o_pnt_scl_val = out_val_q;
    assign o_pnt_scl_sop = out_sop_q;
    assign o_pnt_scl_eop = out_eop_q;
    assign o_pnt_scl_ctl = CTL_BITS'(out_mode_q);
    assign o_pnt_scl_dat = out_dat_q;
    assign o_loaded      = loaded_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_multiexp_pnt_scl_feeder.sv
// Directed bench for multiexp_pnt_scl_feeder with NUM_IN=4, KEY_BITS=3: load tables,
// replay scoreboard against hand-built beat lists, backpressure and reset corner cases.
module tb_multiexp_pnt_scl_feeder;
    localparam int unsigned FPB = 8;
    localparam int unsigned FEB = 8;
    localparam int unsigned W   = FPB + FEB;
    localparam int unsigned KB  = 3;
    localparam int unsigned NI  = 4;
    localparam int unsigned CB  = 8;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_load_val = 1'b0;
    logic          i_load_sop = 1'b0;
    logic [W-1:0]  i_load_dat = '0;
    logic          o_load_rdy;
    logic          o_val, o_sop, o_eop;
    logic [CB-1:0] o_ctl;
    logic [W-1:0]  o_dat;
    logic          i_pnt_scl_rdy = 1'b1;
    logic          i_start = 1'b0;
    logic          i_mode = 1'b0;
    logic          o_loaded, o_busy, o_done;

    multiexp_pnt_scl_feeder #(
        .FP_BITS(FPB), .FE_BITS(FEB), .KEY_BITS(KB), .CTL_BITS(CB), .NUM_IN(NI)
    ) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_load_val(i_load_val), .i_load_sop(i_load_sop), .i_load_dat(i_load_dat),
        .o_load_rdy(o_load_rdy),
        .o_pnt_scl_val(o_val), .o_pnt_scl_sop(o_sop), .o_pnt_scl_eop(o_eop),
        .o_pnt_scl_ctl(o_ctl), .o_pnt_scl_dat(o_dat), .i_pnt_scl_rdy(i_pnt_scl_rdy),
        .i_start(i_start), .i_mode(i_mode),
        .o_loaded(o_loaded), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sop;
        logic [W-1:0] dat;
        logic         exp_loaded;
    } ld_vec_t;

    typedef struct packed {
        logic [W-1:0]  dat;
        logic          sop;
        logic          eop;
        logic [CB-1:0] ctl;
    } beat_t;

    ld_vec_t ld_tab[14];
    beat_t   exp_b[12];
    int      n_chk = 0;
    int      n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            i_load_val = 1'b1;
            i_load_sop = ld_tab[i].sop;
            i_load_dat = ld_tab[i].dat;
            check($sformatf("load_rdy[%0d]", i), 32'(o_load_rdy), 32'd1);
            tick;
            i_load_val = 1'b0;
            i_load_sop = 1'b0;
            check($sformatf("loaded[%0d]", i), 32'(o_loaded), 32'(ld_tab[i].exp_loaded));
        end
    endtask

    task automatic set_exp(input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input logic [W-1:0] e2, input logic [W-1:0] e3);
        logic [W-1:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int p = 0; p < int'(KB); p++) begin
            for (int i = 0; i < int'(NI); i++) begin
                exp_b[p*NI+i].dat = e[i];
                exp_b[p*NI+i].sop = (i == 0);
                exp_b[p*NI+i].eop = (i == int'(NI) - 1);
                exp_b[p*NI+i].ctl = '0;
            end
        end
    endtask

    // Start a replay and score every handshaken beat against exp_b
    task automatic replay(input logic mode, input int exp_n, input bit rand_rdy,
                          input bit mid_start, input bit start_on_done, input string tag);
        int    got = 0;
        int    first_cyc = -1;
        int    last_hs = -1;
        int    done_cyc = -1;
        int    gaps = 0;
        logic  pv = 1'b0;
        logic  pr = 1'b0;
        logic  bad = 1'b0;
        beat_t pb = '0;
        beat_t cur;
        i_mode  = mode;
        i_start = 1'b1;
        tick;
        i_start = 1'b0;
        for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
            i_pnt_scl_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            i_start = mid_start && (cyc == 5);
            cur.dat = o_dat; cur.sop = o_sop; cur.eop = o_eop; cur.ctl = o_ctl;
            if (pv && !pr)
                check({tag, "_hold"}, 32'({o_val, cur}), 32'({1'b1, pb}));
            if (o_val && first_cyc < 0) begin
                first_cyc = cyc;
                check({tag, "_busy"}, 32'(o_busy), 32'd1);
            end
            if (!rand_rdy && first_cyc >= 0 && got < exp_n && !o_val) gaps++;
            if (o_done) begin
                done_cyc = cyc;
                check({tag, "_done_val"}, 32'({o_val, o_busy, o_loaded}), 32'b001);
            end
            if (o_val && i_pnt_scl_rdy) begin
                if (got < exp_n)
                    check($sformatf("%s_beat%0d", tag, got), 32'(cur), 32'(exp_b[got]));
                got++;
                last_hs = cyc;
            end
            pv = o_val; pr = i_pnt_scl_rdy; pb = cur;
            if (done_cyc >= 0 && start_on_done) i_start = 1'b1;
            tick;
        end
        i_start = 1'b0;
        i_pnt_scl_rdy = 1'b1;
        check({tag, "_beats"}, got, exp_n);
        check({tag, "_first_lat"}, first_cyc, 1);
        check({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
        check({tag, "_done_lat"}, done_cyc, last_hs + 1);
        if (!rand_rdy) check({tag, "_gaps"}, gaps, 0);
        for (int k = 0; k < 4; k++) begin
            if (o_val || o_busy || o_done) bad = 1'b1;
            tick;
        end
        check({tag, "_idle_after"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int   got;
        logic bad;
        ld_tab[0]  = '{1'b1, 16'hA001, 1'b0};
        ld_tab[1]  = '{1'b0, 16'hB002, 1'b0};
        ld_tab[2]  = '{1'b0, 16'hC003, 1'b0};
        ld_tab[3]  = '{1'b0, 16'hD004, 1'b1};
        ld_tab[4]  = '{1'b1, 16'h7011, 1'b0};
        ld_tab[5]  = '{1'b0, 16'h7122, 1'b0};
        ld_tab[6]  = '{1'b0, 16'h7233, 1'b0};
        ld_tab[7]  = '{1'b0, 16'h7344, 1'b1};
        ld_tab[8]  = '{1'b1, 16'hA001, 1'b0};
        ld_tab[9]  = '{1'b0, 16'hB002, 1'b0};
        ld_tab[10] = '{1'b1, 16'hE005, 1'b0};
        ld_tab[11] = '{1'b0, 16'hF006, 1'b0};
        ld_tab[12] = '{1'b0, 16'h9007, 1'b0};
        ld_tab[13] = '{1'b0, 16'h8008, 1'b1};

        // Reset values
        tick; tick;
        check("rst_stream", 32'({o_val, o_sop, o_eop, o_ctl, o_dat}), 32'd0);
        check("rst_ctrl", 32'({o_load_rdy, o_loaded, o_busy, o_done}), 32'd0);
        i_rst = 1'b0;
        tick;
        check("rdy_after_rst", 32'(o_load_rdy), 32'd1);

        // Normal replay, full rdy; a start on the done cycle must be ignored
        load_rows(0, 3);
        set_exp(16'hA001, 16'hB002, 16'hC003, 16'hD004);
        replay(1'b0, 12, 1'b0, 1'b0, 1'b1, "norm");

        // Same replay without reload, random backpressure and a start while busy
        replay(1'b0, 12, 1'b1, 1'b1, 1'b0, "bp");
        check("loaded_kept", 32'(o_loaded), 32'd1);

        // Single-add mode
        exp_b[0].dat = 16'hA001; exp_b[0].sop = 1'b1; exp_b[0].eop = 1'b0;
        exp_b[0].ctl = 8'h01;
        replay(1'b1, 1, 1'b0, 1'b0, 1'b0, "single");
        check("single_loaded", 32'(o_loaded), 32'd1);

        // Partial load: start dropped, then completing the load enables replay
        load_rows(4, 6);
        i_mode = 1'b0; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (o_val || o_busy) bad = 1'b1;
            tick;
        end
        check("partial_start_ignored", 32'(bad), 32'd0);
        load_rows(7, 7);
        set_exp(16'h7011, 16'h7122, 16'h7233, 16'h7344);
        replay(1'b0, 12, 1'b0, 1'b0, 1'b0, "partial");

        // Mid-load sop restarts the buffer
        load_rows(8, 13);
        set_exp(16'hE005, 16'hF006, 16'h9007, 16'h8008);
        replay(1'b0, 12, 1'b0, 1'b0, 1'b0, "resop");

        // Reset during pass 2 beat 2
        i_mode = 1'b0; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 100 && got < 6; cyc++) begin
            if (o_val && i_pnt_scl_rdy) got++;
            if (got < 6) tick;
        end
        check("mid_rst_reached", got, 6);
        check("mid_rst_beat", 32'(o_dat), 32'h0000F006);
        i_rst = 1'b1;
        tick;
        check("mid_rst_val", 32'({o_val, o_done, o_loaded, o_busy, o_load_rdy}), 32'd0);
        i_rst = 1'b0;
        tick;
        check("mid_rst_rdy", 32'(o_load_rdy), 32'd1);
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (o_val || o_done || o_busy) bad = 1'b1;
            tick;
        end
        check("mid_rst_quiet", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
